// File: rtl/pong_pkg.sv
// pong_pkg: shared screen constants, quadrature step encoding and paddle mask helper.
//   SCREEN_H / PADDLE_LEN : default screen height and paddle length in rows
//   step_t                : decoded quadrature step (value = Gray index difference mod 4)
//   gray_step()           : classify a transition between two accepted A/B states
//   paddle_mask()         : row mask with bits [pos, pos+len-1] set
package pong_pkg;
    localparam int SCREEN_H   = 32;
    localparam int PADDLE_LEN = 8;

    // Encoded so that the value equals the Gray-index difference modulo 4.
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_ERR  = 2'd2,
        STEP_REV  = 2'd3
    } step_t;

    // Position of an A/B pair in the cycle 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    function automatic step_t gray_step(input logic [1:0] from, input logic [1:0] to);
        logic [1:0] d;
        d = gray_idx(to) - gray_idx(from);
        return step_t'(d);
    endfunction

    function automatic logic [SCREEN_H-1:0] paddle_mask(input int p, input int len);
        logic [SCREEN_H-1:0] m;
        for (int i = 0; i < SCREEN_H; i++) m[i] = (i >= p) && (i < p + len);
        return m;
    endfunction
endpackage

// File: rtl/quad_decoder.sv
// quad_decoder: synchronizes, debounces and Gray-decodes one quadrature encoder.
//   game_clk  in  : game clock
//   reset     in  : asynchronous active-high reset
//   enc_a/b   in  : raw encoder phases, asynchronous
//   step_fwd  out : one-cycle pulse on a forward transition
//   step_rev  out : one-cycle pulse on a reverse transition
//   err       out : one-cycle pulse when both phases changed at once
module quad_decoder
    import pong_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic game_clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    output logic step_fwd,
    output logic step_rev,
    output logic err
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    s1, s2, cand, acc, acc_d;
    logic [CW-1:0] cnt, cnt_n;
    step_t         st;

    // cnt = consecutive cycles the candidate has been seen; saturates at DEBOUNCE.
    always_comb begin
        cnt_n = (s2 != cand) ? CW'(1) : (cnt == CW'(DEBOUNCE)) ? cnt : cnt + 1'b1;
        st    = gray_step(acc_d, acc);
    end

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            cand     <= '0;
            cnt      <= '0;
            acc      <= '0;
            acc_d    <= '0;
            step_fwd <= 1'b0;
            step_rev <= 1'b0;
            err      <= 1'b0;
        end else begin
            s1       <= {enc_a, enc_b};
            s2       <= s1;
            cand     <= s2;
            cnt      <= cnt_n;
            if (cnt_n == CW'(DEBOUNCE)) acc <= s2;
            acc_d    <= acc;
            step_fwd <= st == STEP_FWD;
            step_rev <= st == STEP_REV;
            err      <= st == STEP_ERR;
        end
    end
endmodule

// File: rtl/paddle_encoder.sv
// paddle_encoder: turns one player's quadrature encoder into a saturating paddle position and mask.
//   game_clk  in  : 1 kHz game clock
//   reset     in  : asynchronous active-high reset
//   enc_a/b   in  : encoder phases, asynchronous
//   recenter  in  : force paddle to centre, discarding encoder steps
//   paddle    out : row mask, bits [pos, pos+LEN-1] set
//   pos       out : top row of the paddle, 0..HEIGHT-LEN
//   moved     out : one-cycle pulse when pos changes
//   enc_err   out : one-cycle pulse on an illegal two-phase transition
module paddle_encoder
    import pong_pkg::*;
#(
    parameter  int HEIGHT   = SCREEN_H,
    parameter  int LEN      = PADDLE_LEN,
    parameter  int STEPS    = 4,
    parameter  int DEBOUNCE = 2,
    parameter  int INVERT   = 0,
    localparam int PW       = $clog2(HEIGHT)
) (
    input  logic              game_clk,
    input  logic              reset,
    input  logic              enc_a,
    input  logic              enc_b,
    input  logic              recenter,
    output logic [HEIGHT-1:0] paddle,
    output logic [PW-1:0]     pos,
    output logic              moved,
    output logic              enc_err
);
    localparam logic [PW-1:0]     CENTRE  = PW'((HEIGHT - LEN) / 2);
    localparam logic [PW-1:0]     MAXP    = PW'(HEIGHT - LEN);
    localparam logic signed [4:0] SUB_MAX = 5'(STEPS - 1);
    localparam logic signed [4:0] SUB_MIN = -SUB_MAX;

    logic              step_fwd, step_rev, up, dn, moved_n;
    logic [PW-1:0]     pos_n;
    logic signed [4:0] sub, sub_n;

    quad_decoder #(.DEBOUNCE(DEBOUNCE)) u_dec (
        .game_clk(game_clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .step_fwd(step_fwd),
        .step_rev(step_rev),
        .err     (enc_err)
    );

    // A completed row move at the screen edge still clears the substep.
    always_comb begin
        up      = (INVERT != 0) ? step_rev : step_fwd;
        dn      = (INVERT != 0) ? step_fwd : step_rev;
        pos_n   = pos;
        sub_n   = sub;
        moved_n = 1'b0;
        if (recenter) begin
            pos_n = CENTRE;
            sub_n = '0;
        end else if (up) begin
            if (sub == SUB_MAX) begin
                sub_n = '0;
                if (pos != MAXP) begin
                    pos_n   = pos + 1'b1;
                    moved_n = 1'b1;
                end
            end else begin
                sub_n = sub + 5'sd1;
            end
        end else if (dn) begin
            if (sub == SUB_MIN) begin
                sub_n = '0;
                if (pos != '0) begin
                    pos_n   = pos - 1'b1;
                    moved_n = 1'b1;
                end
            end else begin
                sub_n = sub - 5'sd1;
            end
        end
    end

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            pos    <= CENTRE;
            sub    <= '0;
            moved  <= 1'b0;
            paddle <= HEIGHT'(paddle_mask(int'(CENTRE), LEN));
        end else begin
            pos    <= pos_n;
            sub    <= sub_n;
            moved  <= moved_n;
            paddle <= HEIGHT'(paddle_mask(int'(pos_n), LEN));
        end
    end
endmodule

// File: tb/tb_paddle_encoder.sv
// tb_paddle_encoder: directed stimulus with a window/queue reference model checked every cycle.
module tb_paddle_encoder;
    localparam int D     = 2;
    localparam int STEPS = 4;
    localparam int LEN   = 8;
    localparam int H     = 32;
    localparam int INV   = 0;
    localparam int C     = (H - LEN) / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a = 1'b0, b = 1'b0, rec = 1'b0;
    logic [31:0] paddle;
    logic [4:0]  pos;
    logic        moved, err;

    always #5 clk = ~clk;

    paddle_encoder #(.HEIGHT(H), .LEN(LEN), .STEPS(STEPS), .DEBOUNCE(D), .INVERT(INV)) dut (
        .game_clk(clk),
        .reset   (rst),
        .enc_a   (a),
        .enc_b   (b),
        .recenter(rec),
        .paddle  (paddle),
        .pos     (pos),
        .moved   (moved),
        .enc_err (err)
    );

    int total = 0, bad = 0, errs_seen = 0, moves_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mmask(input int p);
        logic [63:0] m;
        m = ((64'd1 << LEN) - 64'd1) << p;
        return m[31:0];
    endfunction

    function automatic int gidx(input logic [1:0] v);
        return (v == 2'b00) ? 0 : (v == 2'b01) ? 1 : (v == 2'b11) ? 2 : 3;
    endfunction

    // +1 forward, -1 reverse, 2 illegal, 0 none
    function automatic int classify(input logic [1:0] f, input logic [1:0] t);
        int d;
        d = (gidx(t) - gidx(f) + 4) % 4;
        return (d == 1) ? 1 : (d == 3) ? -1 : (d == 2) ? 2 : 0;
    endfunction

    // Reference model: hist[0] is the input sampled at this edge; a value is
    // accepted when it filled the D-deep window seen through the 2-FF delay.
    int         m_pos, m_sub, m_dec, s, np;
    bit         m_moved, m_err, chg_v, stable;
    logic [1:0] m_acc, chg_from, chg_to;
    logic [1:0] hist[$];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pos = C; m_sub = 0; m_dec = 0; m_moved = 0; m_err = 0;
            m_acc = 2'b00; chg_v = 0;
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back(2'b00);
        end else begin
            m_moved = 0;
            s = (m_dec == 2) ? 0 : ((INV != 0) ? -m_dec : m_dec);
            if (rec) begin
                m_pos = C; m_sub = 0;
            end else if (s != 0) begin
                m_sub += s;
                if (m_sub == STEPS || m_sub == -STEPS) begin
                    np = m_pos + m_sub / STEPS;
                    m_sub = 0;
                    if (np >= 0 && np <= H - LEN) begin
                        m_pos = np; m_moved = 1;
                    end
                end
            end
            m_dec = chg_v ? classify(chg_from, chg_to) : 0;
            m_err = (m_dec == 2);
            hist.push_front({a, b});
            void'(hist.pop_back());
            stable = 1;
            for (int k = 2; k <= D + 1; k++) if (hist[k] != hist[2]) stable = 0;
            chg_v = 0;
            if (stable && hist[2] != m_acc) begin
                chg_from = m_acc; chg_to = hist[2]; m_acc = hist[2]; chg_v = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("pos", 64'(pos), 64'(m_pos));
            chk("paddle", 64'(paddle), 64'(mmask(m_pos)));
            chk("moved", 64'(moved), 64'(m_moved));
            chk("enc_err", 64'(err), 64'(m_err));
            if (moved) moves_seen++;
            if (err) errs_seen++;
        end
    end

    task automatic drive(input logic [1:0] v, input int n);
        {a, b} = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic detent(input bit fwd);
        if (fwd) begin
            drive(2'b01, 4); drive(2'b11, 4); drive(2'b10, 4); drive(2'b00, 4);
        end else begin
            drive(2'b10, 4); drive(2'b11, 4); drive(2'b01, 4); drive(2'b00, 4);
        end
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_rec();
        rec = 1'b1;
        @(negedge clk);
        rec = 1'b0;
    endtask

    int n, m0, e0;
    bit got;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_pos", 64'(pos), 64'd12);
        chk("rst_paddle", 64'(paddle), 64'h000F_F000);
        chk("rst_moved", 64'(moved), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (4) @(negedge clk);

        // one detent, measure edge-to-move latency
        m0 = moves_seen;
        drive(2'b01, 4); drive(2'b11, 4); drive(2'b10, 4);
        {a, b} = 2'b00;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); n++;
            #1 if (moved) got = 1;
        end
        chk("latency", 64'(n), 64'(D + 4));
        @(negedge clk);
        settle();
        chk("fwd_pos", 64'(pos), 64'd13);
        chk("fwd_paddle", 64'(paddle), 64'h001F_E000);
        chk("fwd_moves", 64'(moves_seen - m0), 64'd1);

        // saturation at the bottom edge
        pulse_rec();
        m0 = moves_seen;
        repeat (25) detent(1);
        settle();
        chk("sat_pos", 64'(pos), 64'd24);
        chk("sat_paddle", 64'(paddle), 64'hFF00_0000);
        chk("sat_moves", 64'(moves_seen - m0), 64'd12);
        detent(0);
        settle();
        chk("rev_pos", 64'(pos), 64'd23);

        // glitch then illegal jump
        e0 = errs_seen;
        drive(2'b10, 1); drive(2'b00, 12);
        chk("glitch_pos", 64'(pos), 64'd23);
        chk("glitch_err", 64'(errs_seen - e0), 64'd0);
        drive(2'b11, 10);
        chk("jump_err", 64'(errs_seen - e0), 64'd1);
        chk("jump_pos", 64'(pos), 64'd23);
        drive(2'b10, 4); drive(2'b00, 4);
        settle();

        // recenter wins over a completing detent
        pulse_rec();
        repeat (8) detent(1);
        settle();
        chk("pre_rec_pos", 64'(pos), 64'd20);
        drive(2'b01, 4); drive(2'b11, 4); drive(2'b10, 4);
        {a, b} = 2'b00;
        repeat (D + 3) @(posedge clk);
        @(negedge clk);
        rec = 1'b1;
        @(negedge clk);
        rec = 1'b0;
        chk("rec_pos", 64'(pos), 64'd12);
        chk("rec_moved", 64'(moved), 64'd0);
        settle();
        chk("rec_hold", 64'(pos), 64'd12);

        // async reset mid-detent
        drive(2'b01, 4); drive(2'b11, 4);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(2'b10, 4); drive(2'b00, 4);
        settle();
        chk("arst_pos", 64'(pos), 64'd12);
        chk("arst_paddle", 64'(paddle), 64'h000F_F000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
